// File: rtl/vga_timing_rx.sv
// Video input receiver: recovers pixel x/y from a raw h/v sync + RGB stream,
// qualifies active pixels and declares lock once line/frame lengths match the mode.
module vga_timing_rx #(
  parameter int   H_TOTAL_WIDTH = 11,
  parameter int   V_TOTAL_WIDTH = 11,
  parameter logic POLARITY      = 1'b1,
  parameter int   H_SYNC        = 120,
  parameter int   H_BACK        = 64,
  parameter int   H_ACT         = 800,
  parameter int   H_FRONT       = 56,
  parameter int   V_SYNC        = 6,
  parameter int   V_BACK        = 23,
  parameter int   V_ACT         = 600,
  parameter int   V_FRONT       = 37,
  parameter int   LOCK_FRAMES   = 2
) (
  input  logic                     clock,
  input  logic                     aresetn,
  input  logic                     h_sync_in,
  input  logic                     v_sync_in,
  input  logic [7:0]               R_in,
  input  logic [7:0]               G_in,
  input  logic [7:0]               B_in,
  output logic [H_TOTAL_WIDTH-1:0] current_x,
  output logic [V_TOTAL_WIDTH-1:0] current_y,
  output logic                     pix_valid,
  output logic [7:0]               R_out,
  output logic [7:0]               G_out,
  output logic [7:0]               B_out,
  output logic                     frame_start,
  output logic                     locked,
  output logic                     sync_err
);

  localparam int HW = H_TOTAL_WIDTH;
  localparam int VW = V_TOTAL_WIDTH;
  localparam logic [HW-1:0] H_LAST = HW'(H_SYNC + H_BACK + H_ACT + H_FRONT - 1);
  localparam logic [HW-1:0] H_OFF  = HW'(H_SYNC + H_BACK);
  localparam logic [HW-1:0] H_END  = HW'(H_SYNC + H_BACK + H_ACT);
  localparam logic [VW-1:0] V_LAST = VW'(V_SYNC + V_BACK + V_ACT + V_FRONT - 1);
  localparam logic [VW-1:0] V_OFF  = VW'(V_SYNC + V_BACK);
  localparam logic [VW-1:0] V_END  = VW'(V_SYNC + V_BACK + V_ACT);
  localparam logic [3:0]    GOOD_LOCK = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {ST_SEARCH = 2'd0, ST_MEASURE = 2'd1, ST_LOCKED = 2'd2} state_t;

  function automatic logic [HW-1:0] sat_inc_h(input logic [HW-1:0] v);
    return (v == '1) ? v : v + HW'(1);
  endfunction

  function automatic logic [VW-1:0] sat_inc_v(input logic [VW-1:0] v);
    return (v == '1) ? v : v + VW'(1);
  endfunction

  logic          r_hs_p0, r_vs_p0, r_hs_d_p0, r_vs_d_p0;
  logic [23:0]   r_rgb_p0;
  logic [HW-1:0] r_h_cnt;
  logic [VW-1:0] r_v_cnt;
  logic          r_h_seen, r_v_seen, r_line_bad;
  state_t        r_state, w_state_nx;
  logic [3:0]    r_good, w_good_nx;
  logic          w_hs_edge, w_vs_edge, w_line_bad, w_frame_bad, w_err, w_locked, w_active;
  logic          r_vld_p1, r_fs_p1, r_err_p1;
  logic [HW-1:0] r_x_p1;
  logic [VW-1:0] r_y_p1;
  logic [23:0]   r_rgb_p1;

  // Stage 1: input capture, syncs normalised to active-high
  always_ff @(posedge clock or negedge aresetn) begin
    if (!aresetn) begin
      r_hs_p0   <= 1'b0;
      r_vs_p0   <= 1'b0;
      r_hs_d_p0 <= 1'b0;
      r_vs_d_p0 <= 1'b0;
      r_rgb_p0  <= '0;
    end else begin
      r_hs_p0   <= h_sync_in ^ ~POLARITY;
      r_vs_p0   <= v_sync_in ^ ~POLARITY;
      r_hs_d_p0 <= r_hs_p0;
      r_vs_d_p0 <= r_vs_p0;
      r_rgb_p0  <= {R_in, G_in, B_in};
    end
  end

  assign w_hs_edge = r_hs_p0 & ~r_hs_d_p0;
  assign w_vs_edge = r_vs_p0 & ~r_vs_d_p0;

  // The first edge after reset only starts measurement; it closes no interval.
  assign w_line_bad  = w_hs_edge & r_h_seen & ((r_h_cnt != H_LAST) | (r_h_cnt == '1));
  assign w_frame_bad = w_vs_edge & r_v_seen &
                       ((r_v_cnt != V_LAST) | (r_v_cnt == '1) | r_line_bad | w_line_bad);

  always_ff @(posedge clock or negedge aresetn) begin
    if (!aresetn) begin
      r_h_cnt    <= '0;
      r_v_cnt    <= '0;
      r_h_seen   <= 1'b0;
      r_v_seen   <= 1'b0;
      r_line_bad <= 1'b0;
    end else begin
      r_h_cnt <= w_hs_edge ? '0 : sat_inc_h(r_h_cnt);
      if (w_vs_edge)      r_v_cnt <= '0;
      else if (w_hs_edge) r_v_cnt <= sat_inc_v(r_v_cnt);
      if (w_hs_edge) r_h_seen <= 1'b1;
      if (w_vs_edge) r_v_seen <= 1'b1;
      // A bad line on the vs_edge cycle belongs to the frame just closed
      if (w_vs_edge)       r_line_bad <= 1'b0;
      else if (w_line_bad) r_line_bad <= 1'b1;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_good_nx  = r_good;
    w_err      = 1'b0;
    case (r_state)
      ST_SEARCH: begin
        if (w_vs_edge) begin
          w_state_nx = ST_MEASURE;
          w_good_nx  = '0;
        end
      end
      ST_MEASURE: begin
        w_err = w_line_bad | w_frame_bad;
        if (w_frame_bad) begin
          w_good_nx = '0;
        end else if (w_vs_edge) begin
          if (r_good + 4'd1 >= GOOD_LOCK) begin
            w_state_nx = ST_LOCKED;
            w_good_nx  = '0;
          end else begin
            w_good_nx = r_good + 4'd1;
          end
        end
      end
      ST_LOCKED: begin
        w_err = w_line_bad | w_frame_bad;
        if (w_err) begin
          w_state_nx = ST_SEARCH;
          w_good_nx  = '0;
        end
      end
      default: begin
        w_state_nx = ST_SEARCH;
        w_good_nx  = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= ST_SEARCH;
      r_good  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_good  <= w_good_nx;
    end
  end

  assign w_locked = (r_state == ST_LOCKED);
  assign w_active = w_locked & (r_h_cnt >= H_OFF) & (r_h_cnt < H_END) &
                    (r_v_cnt >= V_OFF) & (r_v_cnt < V_END);

  // Stage 2: registered outputs, blanked outside the active window
  always_ff @(posedge clock or negedge aresetn) begin
    if (!aresetn) begin
      r_vld_p1 <= 1'b0;
      r_x_p1   <= '0;
      r_y_p1   <= '0;
      r_rgb_p1 <= '0;
      r_fs_p1  <= 1'b0;
      r_err_p1 <= 1'b0;
    end else begin
      r_vld_p1 <= w_active;
      r_x_p1   <= w_active ? r_h_cnt - H_OFF : '0;
      r_y_p1   <= w_active ? r_v_cnt - V_OFF : '0;
      r_rgb_p1 <= w_active ? r_rgb_p0 : '0;
      r_fs_p1  <= w_active & (r_h_cnt == H_OFF) & (r_v_cnt == V_OFF);
      r_err_p1 <= w_err;
    end
  end

  assign pix_valid   = r_vld_p1;
  assign current_x   = r_x_p1;
  assign current_y   = r_y_p1;
  assign R_out       = r_rgb_p1[23:16];
  assign G_out       = r_rgb_p1[15:8];
  assign B_out       = r_rgb_p1[7:0];
  assign frame_start = r_fs_p1;
  assign locked      = w_locked;
  assign sync_err    = r_err_p1;

endmodule

// File: tb/tb_vga_timing_rx.sv
// Bench for vga_timing_rx: a small video mode driven into an active-high and an
// active-low instance, each output cycle checked against a position-derived scoreboard.
module tb_vga_timing_rx;

  localparam int H_SYNC = 4, H_BACK = 3, H_ACT = 8, H_FRONT = 2;
  localparam int V_SYNC = 2, V_BACK = 2, V_ACT = 5, V_FRONT = 2;
  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACT + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACT + V_FRONT;
  localparam int H_OFF = H_SYNC + H_BACK;
  localparam int V_OFF = V_SYNC + V_BACK;
  localparam int FULL = H_ACT * V_ACT;

  typedef struct packed {
    logic        vld;
    logic [10:0] x;
    logic [10:0] y;
    logic [23:0] rgb;
    logic        fs;
    logic        lk;
    logic        err;
  } out_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic hs, vs, hs_n, vs_n;
  logic [7:0] r_in, g_in, b_in;
  logic [10:0] p_x, p_y, n_x, n_y;
  logic p_vld, p_fs, p_lk, p_err, n_vld, n_fs, n_lk, n_err;
  logic [7:0] p_r, p_g, p_b, n_r, n_g, n_b;
  out_t obs_p, obs_n;

  always #5 clk = ~clk;

  assign hs_n  = ~hs;
  assign vs_n  = ~vs;
  assign obs_p = {p_vld, p_x, p_y, p_r, p_g, p_b, p_fs, p_lk, p_err};
  assign obs_n = {n_vld, n_x, n_y, n_r, n_g, n_b, n_fs, n_lk, n_err};

  vga_timing_rx #(
    .POLARITY(1'b1),
    .H_SYNC(H_SYNC), .H_BACK(H_BACK), .H_ACT(H_ACT), .H_FRONT(H_FRONT),
    .V_SYNC(V_SYNC), .V_BACK(V_BACK), .V_ACT(V_ACT), .V_FRONT(V_FRONT),
    .LOCK_FRAMES(2)
  ) dut (
    .clock(clk), .aresetn(rst_n), .h_sync_in(hs), .v_sync_in(vs),
    .R_in(r_in), .G_in(g_in), .B_in(b_in),
    .current_x(p_x), .current_y(p_y), .pix_valid(p_vld),
    .R_out(p_r), .G_out(p_g), .B_out(p_b),
    .frame_start(p_fs), .locked(p_lk), .sync_err(p_err)
  );

  vga_timing_rx #(
    .POLARITY(1'b0),
    .H_SYNC(H_SYNC), .H_BACK(H_BACK), .H_ACT(H_ACT), .H_FRONT(H_FRONT),
    .V_SYNC(V_SYNC), .V_BACK(V_BACK), .V_ACT(V_ACT), .V_FRONT(V_FRONT),
    .LOCK_FRAMES(2)
  ) dut_n (
    .clock(clk), .aresetn(rst_n), .h_sync_in(hs_n), .v_sync_in(vs_n),
    .R_in(r_in), .G_in(g_in), .B_in(b_in),
    .current_x(n_x), .current_y(n_y), .pix_valid(n_vld),
    .R_out(n_r), .G_out(n_g), .B_out(n_b),
    .frame_start(n_fs), .locked(n_lk), .sync_err(n_err)
  );

  int   checks = 0;
  int   errors = 0;
  out_t sb[$];
  logic lk, err_now, t2;
  int   n_vld_p, n_vld_n, n_fs_p, n_fs_n;

  task automatic chk_out(input string tag, input out_t obs, input out_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One pixel clock: check the output owed by the input driven two steps ago,
  // then drive line L / column j and queue the output it must produce.
  task automatic step(input int L, input int j);
    out_t e;
    out_t exp_o;
    logic [23:0] d;
    @(negedge clk);
    if (sb.size() >= 2) begin
      exp_o = sb.pop_front();
      chk_out("pol1_out", obs_p, exp_o);
      chk_out("pol0_out", obs_n, exp_o);
      n_vld_p += int'(p_vld);
      n_vld_n += int'(n_vld);
      n_fs_p  += int'(p_fs);
      n_fs_n  += int'(n_fs);
    end
    if (t2) d = (L == V_OFF && j == H_OFF + 1) ? 24'hA50000 : 24'h000000;
    else    d = 24'($urandom);
    hs = (j < H_SYNC);
    vs = (L < V_SYNC);
    {r_in, g_in, b_in} = d;
    e.vld = lk && (j - 1 >= H_OFF) && (j - 1 < H_OFF + H_ACT) &&
            (L >= V_OFF) && (L < V_OFF + V_ACT);
    e.x   = e.vld ? 11'(j - 1 - H_OFF) : 11'd0;
    e.y   = e.vld ? 11'(L - V_OFF) : 11'd0;
    e.rgb = e.vld ? d : 24'd0;
    e.fs  = e.vld && (e.x == 11'd0) && (e.y == 11'd0);
    e.lk  = lk;
    e.err = err_now;
    sb.push_back(e);
  endtask

  // lk_vs/err_vs: expected lock/error from the frame's vs edge onward;
  // long_line gets one extra pixel, detected at the next line start.
  task automatic frame(input int n_lines, input int long_line, input logic lk_vs,
                       input logic err_vs, input logic err_line, input int exp_vld,
                       input int stop_line, input int stop_idx);
    int len;
    n_vld_p = 0; n_vld_n = 0; n_fs_p = 0; n_fs_n = 0;
    for (int L = 0; L < n_lines; L++) begin
      len = (L == long_line) ? H_TOTAL + 1 : H_TOTAL;
      for (int j = 0; j < len; j++) begin
        if (L == stop_line && j == stop_idx) return;
        err_now = 1'b0;
        if (L == 0 && j == 0) begin
          lk = lk_vs;
          err_now = err_vs;
        end else if (L == long_line + 1 && j == 0) begin
          lk = 1'b0;
          err_now = err_line;
        end
        step(L, j);
      end
    end
    if (exp_vld >= 0) begin
      chk_int("pol1_valid_count", n_vld_p, exp_vld);
      chk_int("pol0_valid_count", n_vld_n, exp_vld);
      chk_int("pol1_frame_start_count", n_fs_p, (exp_vld > 0) ? 1 : 0);
      chk_int("pol0_frame_start_count", n_fs_n, (exp_vld > 0) ? 1 : 0);
    end
  endtask

  initial begin
    hs = 1'b0; vs = 1'b0; r_in = '0; g_in = '0; b_in = '0;
    lk = 1'b0; err_now = 1'b0; t2 = 1'b0;
    repeat (3) @(negedge clk);
    chk_out("pol1_reset", obs_p, '0);
    chk_out("pol0_reset", obs_n, '0);
    rst_n = 1'b1;

    // Acquisition on a nominal stream, both sync polarities
    frame(V_TOTAL, -1, 1'b0, 1'b0, 1'b0, 0, -1, -1);
    frame(V_TOTAL, -1, 1'b0, 1'b0, 1'b0, 0, -1, -1);
    frame(V_TOTAL, -1, 1'b1, 1'b0, 1'b0, FULL, -1, -1);

    // Single marked pixel at the first active position
    t2 = 1'b1;
    frame(V_TOTAL, -1, 1'b1, 1'b0, 1'b0, FULL, -1, -1);
    t2 = 1'b0;

    // Over-long line while locked, then relock
    frame(V_TOTAL, 5, 1'b1, 1'b0, 1'b1, 2 * H_ACT, -1, -1);
    frame(V_TOTAL, -1, 1'b0, 1'b0, 1'b0, 0, -1, -1);
    frame(V_TOTAL, -1, 1'b0, 1'b0, 1'b0, 0, -1, -1);
    frame(V_TOTAL, -1, 1'b1, 1'b0, 1'b0, -1, 6, 9);

    // Asynchronous reset in the middle of an active line
    #2 rst_n = 1'b0;
    #1;
    chk_out("pol1_midline_reset", obs_p, '0);
    chk_out("pol0_midline_reset", obs_n, '0);
    sb.delete();
    lk = 1'b0;
    hs = 1'b0;
    vs = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Reacquire with a short frame during measurement
    frame(V_TOTAL, -1, 1'b0, 1'b0, 1'b0, 0, -1, -1);
    frame(V_TOTAL - 1, -1, 1'b0, 1'b0, 1'b0, 0, -1, -1);
    frame(V_TOTAL, -1, 1'b0, 1'b1, 1'b0, 0, -1, -1);
    frame(V_TOTAL, -1, 1'b0, 1'b0, 1'b0, 0, -1, -1);
    frame(V_TOTAL, -1, 1'b1, 1'b0, 1'b0, FULL, -1, -1);
    frame(V_TOTAL, -1, 1'b1, 1'b0, 1'b0, -1, 2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
